// File: rtl/axi_bridge_pkg.sv
// Shared constants, types and helpers for the SRAM-like to AXI bridge.
package axi_bridge_pkg;

    // AXI IDs: reads carry the requesting port, writes always use INST_ID
    localparam int INST_ID = 0;
    localparam int DATA_ID = 1;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    // SRAM-like size encodings (bytes = 1 << size)
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Write slot progress: AW and W handshake independently before B
    typedef enum logic [2:0] {
        WR_IDLE,
        WR_BOTH,
        WR_WAIT_AW,
        WR_WAIT_W,
        WR_RESP
    } wr_state_e;

    // SRAM size to AXI AxSIZE; size 3 is not a legal 32-bit beat, send a word
    function automatic logic [2:0] axsize_of(input logic [1:0] size);
        return (size == 2'd3) ? {1'b0, SIZE_WORD} : {1'b0, size};
    endfunction

    // Byte lanes for a single beat at the given byte offset
    function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << offset;
            SIZE_HALF: strb = 4'b0011 << offset;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/axi_rd_tracker.sv
// Outstanding-read counter for one SRAM port (0..MAX_RD).
module axi_rd_tracker #(
    parameter int MAX_RD = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [2:0] count_reg;
    logic       dec_eff;

    // A return for a port with nothing outstanding never underflows
    assign dec_eff = dec && !empty;

    // Count accepted reads up, completed reads down; both at once cancel
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else begin
            case ({inc, dec_eff})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign full  = (count_reg == 3'(MAX_RD));
    assign empty = (count_reg == 3'd0);

endmodule

// File: rtl/axi_sram_bridge.sv
// Two SRAM-like ports (inst, data) bridged onto one AXI master.
// One AR slot shared by both ports, one write slot, per-port read tracking.
module axi_sram_bridge
    import axi_bridge_pkg::*;
#(
    parameter int MAX_RD = 2,
    parameter int ID_W   = 4
) (
    input  logic            clk,
    input  logic            resetn,
    // instruction port
    input  logic            inst_req,
    input  logic            inst_wr,
    input  logic [1:0]      inst_size,
    input  logic [31:0]     inst_addr,
    input  logic [31:0]     inst_wdata,
    output logic [31:0]     inst_rdata,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,
    // data port
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [1:0]      data_size,
    input  logic [31:0]     data_addr,
    input  logic [31:0]     data_wdata,
    output logic [31:0]     data_rdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,
    // AR
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    // R
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    // AW
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    // W
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    // B
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    // Port index 0 = inst, 1 = data; matches the read IDs
    logic [1:0]      rd_ok;
    logic [1:0]      rd_full;
    logic [1:0]      rd_empty;
    logic [1:0]      r_match;

    logic            ar_valid_reg;
    logic [31:0]     ar_addr_reg;
    logic [2:0]      ar_size_reg;
    logic [ID_W-1:0] ar_id_reg;
    logic            ar_free;
    logic            rd_load;

    wr_state_e       wr_state_reg;
    wr_state_e       wr_state_next;
    logic [31:0]     wr_addr_reg;
    logic [1:0]      wr_size_reg;
    logic [31:0]     wr_data_reg;
    logic            wr_port_reg;
    logic            wr_idle;
    logic            wr_load;
    logic            inst_wr_ok;
    logic            data_wr_ok;
    logic            inst_hazard;
    logic            data_hazard;
    logic            b_hs;
    logic            b_conflict;

    // Response fields that this bridge deliberately does not act on
    logic            unused_resp;
    assign unused_resp = ^{rresp, rlast, bid, bresp};

    // ---------------- request acceptance ----------------
    assign ar_free = !ar_valid_reg || arready;
    assign wr_idle = (wr_state_reg == WR_IDLE);

    // A read may not overtake a pending write to the same word
    assign inst_hazard = !wr_idle && (inst_addr[31:2] == wr_addr_reg[31:2]);
    assign data_hazard = !wr_idle && (data_addr[31:2] == wr_addr_reg[31:2]);

    // Data port always wins; inst is locked out whenever data requests
    assign rd_ok[1]   = data_req && !data_wr && ar_free && !rd_full[1] && !data_hazard;
    assign rd_ok[0]   = inst_req && !inst_wr && !data_req && ar_free && !rd_full[0] && !inst_hazard;
    assign data_wr_ok = data_req && data_wr && wr_idle;
    assign inst_wr_ok = inst_req && inst_wr && !data_req && wr_idle;

    assign data_addr_ok = rd_ok[1] | data_wr_ok;
    assign inst_addr_ok = rd_ok[0] | inst_wr_ok;

    assign rd_load = |rd_ok;
    assign wr_load = data_wr_ok | inst_wr_ok;

    // ---------------- read tracking per port ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign r_match[gi] = rvalid && (rid == ID_W'(gi)) && !rd_empty[gi];

            axi_rd_tracker #(
                .MAX_RD(MAX_RD)
            ) u_trk (
                .clk   (clk),
                .resetn(resetn),
                .inc   (rd_ok[gi]),
                .dec   (r_match[gi]),
                .full  (rd_full[gi]),
                .empty (rd_empty[gi])
            );
        end
    endgenerate

    // Accept any beat while something is outstanding; stray IDs are drained
    assign rready     = |(~rd_empty);
    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    // ---------------- AR slot ----------------
    // Slot valid: set on accepted read, cleared once the slave takes it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_valid_reg <= 1'b0;
        end else if (rd_load) begin
            ar_valid_reg <= 1'b1;
        end else if (arready) begin
            ar_valid_reg <= 1'b0;
        end
    end

    // AR holding registers, loaded from the winning port
    always_ff @(posedge clk) begin
        if (rd_load) begin
            ar_addr_reg <= rd_ok[1] ? data_addr : inst_addr;
            ar_size_reg <= axsize_of(rd_ok[1] ? data_size : inst_size);
            ar_id_reg   <= rd_ok[1] ? ID_W'(DATA_ID) : ID_W'(INST_ID);
        end
    end

    assign arvalid = ar_valid_reg;
    assign araddr  = ar_addr_reg;
    assign arsize  = ar_size_reg;
    assign arid    = ar_id_reg;
    assign arlen   = LEN_SINGLE;
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    // ---------------- write slot ----------------
    // A read return to the write's own port takes the data_ok this cycle
    assign b_conflict = r_match[wr_port_reg];
    assign bready     = (wr_state_reg == WR_RESP) && !b_conflict;
    assign b_hs       = bvalid && bready;

    // Write slot state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state_reg <= WR_IDLE;
        end else begin
            wr_state_reg <= wr_state_next;
        end
    end

    // Write slot next state: AW and W retire independently, then wait for B
    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            WR_IDLE: begin
                if (wr_load) wr_state_next = WR_BOTH;
            end
            WR_BOTH: begin
                case ({awready, wready})
                    2'b11:   wr_state_next = WR_RESP;
                    2'b10:   wr_state_next = WR_WAIT_W;
                    2'b01:   wr_state_next = WR_WAIT_AW;
                    default: wr_state_next = WR_BOTH;
                endcase
            end
            WR_WAIT_AW: begin
                if (awready) wr_state_next = WR_RESP;
            end
            WR_WAIT_W: begin
                if (wready) wr_state_next = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs) wr_state_next = WR_IDLE;
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    // Write holding registers: address, size, data and originating port
    always_ff @(posedge clk) begin
        if (wr_load) begin
            wr_addr_reg <= data_wr_ok ? data_addr  : inst_addr;
            wr_size_reg <= data_wr_ok ? data_size  : inst_size;
            wr_data_reg <= data_wr_ok ? data_wdata : inst_wdata;
            wr_port_reg <= data_wr_ok;
        end
    end

    assign awvalid = (wr_state_reg == WR_BOTH) || (wr_state_reg == WR_WAIT_AW);
    assign wvalid  = (wr_state_reg == WR_BOTH) || (wr_state_reg == WR_WAIT_W);
    assign awid    = ID_W'(INST_ID);
    assign awaddr  = wr_addr_reg;
    assign awlen   = LEN_SINGLE;
    assign awsize  = axsize_of(wr_size_reg);
    assign awburst = BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign wid     = ID_W'(INST_ID);
    assign wdata   = wr_data_reg;
    assign wstrb   = wstrb_of(wr_size_reg, wr_addr_reg[1:0]);
    assign wlast   = 1'b1;

    // ---------------- completion ----------------
    assign inst_data_ok = r_match[0] || (b_hs && !wr_port_reg);
    assign data_data_ok = r_match[1] || (b_hs &&  wr_port_reg);

endmodule
